// File: rtl/pipe_adder_seg_if.sv
// Operand/result stream bundle for pipe_adder_seg.
// slave is the adder's view; master is the producer/consumer side.
interface pipe_adder_seg_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  a, b, cin, sub, in_valid, out_ready,
      output in_ready, sum, carry, overflow, out_valid
   );

   modport master (
      output a, b, cin, sub, in_valid, out_ready,
      input  in_ready, sum, carry, overflow, out_valid
   );
endinterface

// File: rtl/pipe_adder_seg.sv
// Segmented pipelined adder/subtractor: one SEG-bit carry ripple per stage, WIDTH/SEG stages.
// Define SCAN_CHAIN_EN to add a scan shift chain through every pipeline flop. WIDTH must be a multiple of SEG.
module pipe_adder_seg #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic clk,
   input  logic rst,
   pipe_adder_seg_if.slave s_bus
`ifdef SCAN_CHAIN_EN
   ,
   input  logic i_scan_en,
   input  logic i_scan_in,
   output logic o_scan_out
`endif
);
   localparam int S = WIDTH / SEG;

   // Per-stage inputs, zero-extended to WIDTH so every stage sees the same shape.
   logic [WIDTH-1:0] w_opa [S];
   logic [WIDTH-1:0] w_opb [S];
   logic [WIDTH-1:0] w_rin [S];
   logic             w_cin [S];
   logic             w_vin [S];

   logic [WIDTH-1:0] w_res_last;
   logic             w_c_last;
   logic             w_v_last;
   logic             w_ovf_last;
   logic             w_advance;

`ifdef SCAN_CHAIN_EN
   logic w_sin [S+1];
   assign w_sin[0]   = i_scan_in;
   assign o_scan_out = w_sin[S];
`endif

   assign w_opa[0] = s_bus.a;
   assign w_opb[0] = s_bus.sub ? ~s_bus.b : s_bus.b;
   assign w_cin[0] = s_bus.sub | s_bus.cin;
   assign w_rin[0] = '0;
   assign w_vin[0] = s_bus.in_valid;

   assign w_advance = !(w_v_last && !s_bus.out_ready);

`ifdef SCAN_CHAIN_EN
   assign s_bus.in_ready = w_advance && !i_scan_en;
`else
   assign s_bus.in_ready = w_advance;
`endif

   assign s_bus.sum       = w_res_last;
   assign s_bus.carry     = w_c_last;
   assign s_bus.overflow  = w_ovf_last;
   assign s_bus.out_valid = w_v_last;

   for (genvar gi = 0; gi < S; gi++) begin : g_stage
      localparam int RW = (gi + 1) * SEG;

      logic [SEG:0]     w_sum;
      logic [WIDTH-1:0] w_rnew;
      logic             r_v;
      logic             r_c;
      logic [RW-1:0]    r_res;

      assign w_sum  = {1'b0, w_opa[gi][SEG-1:0]} + {1'b0, w_opb[gi][SEG-1:0]}
                    + {{SEG{1'b0}}, w_cin[gi]};
      assign w_rnew = w_rin[gi] | (WIDTH'(w_sum[SEG-1:0]) << (gi * SEG));

      if (gi < S - 1) begin : g_mid
         localparam int OW = WIDTH - RW;
         logic [OW-1:0] r_opa;
         logic [OW-1:0] r_opb;

`ifdef SCAN_CHAIN_EN
         localparam int L = 2 + RW + 2 * OW;
         logic [L-1:0] w_chain;
         assign w_chain     = {r_opb, r_opa, r_res, r_c, r_v};
         assign w_sin[gi+1] = w_chain[L-1];
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_v   <= 1'b0;
               r_c   <= 1'b0;
               r_res <= '0;
               r_opa <= '0;
               r_opb <= '0;
            end
`ifdef SCAN_CHAIN_EN
            else if (i_scan_en) begin
               {r_opb, r_opa, r_res, r_c, r_v} <= {w_chain[L-2:0], w_sin[gi]};
            end
`endif
            else if (w_advance) begin
               r_v   <= w_vin[gi];
               r_c   <= w_sum[SEG];
               r_res <= RW'(w_rnew);
               r_opa <= OW'(w_opa[gi] >> SEG);
               r_opb <= OW'(w_opb[gi] >> SEG);
            end
         end

         assign w_opa[gi+1] = {{RW{1'b0}}, r_opa};
         assign w_opb[gi+1] = {{RW{1'b0}}, r_opb};
         assign w_rin[gi+1] = {{OW{1'b0}}, r_res};
         assign w_cin[gi+1] = r_c;
         assign w_vin[gi+1] = r_v;
      end else begin : g_last
         logic r_ovf;
         logic w_cmsb;

         // Carry into the MSB recovered from the MSB sum bit and its operand bits.
         assign w_cmsb = w_sum[SEG-1] ^ w_opa[gi][SEG-1] ^ w_opb[gi][SEG-1];

`ifdef SCAN_CHAIN_EN
         localparam int L = 3 + RW;
         logic [L-1:0] w_chain;
         assign w_chain     = {r_ovf, r_res, r_c, r_v};
         assign w_sin[gi+1] = w_chain[L-1];
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_v   <= 1'b0;
               r_c   <= 1'b0;
               r_res <= '0;
               r_ovf <= 1'b0;
            end
`ifdef SCAN_CHAIN_EN
            else if (i_scan_en) begin
               {r_ovf, r_res, r_c, r_v} <= {w_chain[L-2:0], w_sin[gi]};
            end
`endif
            else if (w_advance) begin
               r_v   <= w_vin[gi];
               r_c   <= w_sum[SEG];
               r_res <= RW'(w_rnew);
               r_ovf <= w_cmsb ^ w_sum[SEG];
            end
         end

         assign w_res_last = WIDTH'(r_res);
         assign w_c_last   = r_c;
         assign w_v_last   = r_v;
         assign w_ovf_last = r_ovf;
      end
   end
endmodule

// File: tb/tb_pipe_adder_seg.sv
// Bench for pipe_adder_seg: directed table, backpressure/reset sequences, random vs. arithmetic model.
// The scan section is compiled only when SCAN_CHAIN_EN is defined.
module tb_pipe_adder_seg;
   localparam int WIDTH = 16;
   localparam int SEG   = 4;
   localparam int S     = WIDTH / SEG;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] sum;
      logic        carry;
      logic        ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_adder_seg_if #(.WIDTH(WIDTH)) bus ();

`ifdef SCAN_CHAIN_EN
   logic scan_en;
   logic scan_in;
   logic scan_out;
   pipe_adder_seg #(.WIDTH(WIDTH), .SEG(SEG)) dut (
      .clk(clk), .rst(rst), .s_bus(bus),
      .i_scan_en(scan_en), .i_scan_in(scan_in), .o_scan_out(scan_out)
   );
`else
   pipe_adder_seg #(.WIDTH(WIDTH), .SEG(SEG)) dut (
      .clk(clk), .rst(rst), .s_bus(bus)
   );
`endif

   int errors = 0;
   int checks = 0;
   vec_t vecs [8];
   logic [17:0] expq [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, result packed as {ovf, carry, sum}.
   function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic sub);
      logic [15:0] bp;
      logic [16:0] full;
      logic        ovf;
      bp   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bp} + 17'(sub ? 1'b1 : cin);
      ovf  = (a[15] == bp[15]) && (full[15] != a[15]);
      return {ovf, full[16], full[15:0]};
   endfunction

   task automatic run_vec(input vec_t v, input string name);
      @(posedge clk); #1;
      bus.a = v.a; bus.b = v.b; bus.cin = v.cin; bus.sub = v.sub;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (S - 2) @(posedge clk);
      #1 check({name, "_early"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, "_result"}, {14'd0, bus.overflow, bus.carry, bus.sum},
            {14'd0, v.ovf, v.carry, v.sum});
      $display("vec %s a=%h b=%h cin=%0d sub=%0d -> sum=%h carry=%0d ovf=%0d", name,
               v.a, v.b, v.cin, v.sub, bus.sum, bus.carry, bus.overflow);
   endtask

   initial begin
      logic [15:0] bp_exp [4];
      logic [96:0] pat;
      int idx;
      bit stale;
      logic [17:0] e;

      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
      vecs[5] = '{16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

      rst = 1'b1;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
`ifdef SCAN_CHAIN_EN
      scan_en = 1'b0; scan_in = 1'b0;
`endif
      #2;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_outputs", {14'd0, bus.overflow, bus.carry, bus.sum}, 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("tbl%0d", i));
      @(posedge clk); #1;
      check("flush_idle", 32'(bus.out_valid), 32'd0);

      // Streaming with a 3-cycle output stall.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.a = 16'(i + 1); bus.b = 16'(i + 1); bus.cin = 1'b0; bus.sub = 1'b0;
         bus.in_valid = 1'b1;
         bp_exp[i] = 16'(2 * (i + 1));
         check("bp_accept", 32'(bus.in_ready), 32'd1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("bp_stall_valid", 32'(bus.out_valid), 32'd1);
         check("bp_stall_sum", 32'(bus.sum), 32'h0002);
         check("bp_stall_in_ready", 32'(bus.in_ready), 32'd0);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      idx = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (bus.out_valid) begin
            if (idx < 4) check("bp_order", 32'(bus.sum), 32'(bp_exp[idx]));
            else check("bp_duplicate", 32'(idx), 32'd4);
            $display("bp out %0d sum=%h", idx, bus.sum);
            idx++;
         end
         @(posedge clk); #1;
      end
      check("bp_count", 32'(idx), 32'd4);

      // Reset with three items in flight, first one parked at the output.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.a = 16'h1111 << i; bus.b = 16'h2222 << i; bus.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_pre_valid", 32'(bus.out_valid), 32'd1);
      check("mid_pre_sum", 32'(bus.sum), 32'h3333);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_outputs", {14'd0, bus.overflow, bus.carry, bus.sum}, 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      stale = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (bus.out_valid) stale = 1'b1;
         @(posedge clk); #1;
      end
      check("mid_no_stale", 32'(stale), 32'd0);
      run_vec('{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0}, "post_rst");

`ifdef SCAN_CHAIN_EN
      @(posedge clk); #1;
      pat = 97'd1 << 37;
      scan_en = 1'b1;
      for (int i = 0; i < 193; i++) begin
         scan_in = (i < 97) ? pat[i] : 1'b0;
         #1 check("scan_in_ready", 32'(bus.in_ready), 32'd0);
         @(posedge clk); #1;
         if (i >= 96) check("scan_out", 32'(scan_out), 32'(pat[i-96]));
      end
      $display("scan chain shifted 97-bit walking one");
      scan_en = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
`else
      pat = '0;
`endif

      // Random traffic against the arithmetic model.
      expq.delete();
      for (int n = 0; n < 10000; n++) begin
         @(posedge clk); #1;
         bus.a = 16'($urandom); bus.b = 16'($urandom);
         bus.cin = 1'($urandom); bus.sub = 1'($urandom);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
               check("rnd_spurious", 32'(bus.out_valid), 32'd0);
            end else begin
               e = expq.pop_front();
               check("rnd_result", {14'd0, bus.overflow, bus.carry, bus.sum}, {14'd0, e});
               $display("rnd out sum=%h carry=%0d ovf=%0d", bus.sum, bus.carry, bus.overflow);
            end
         end
         if (bus.in_valid && bus.in_ready)
            expq.push_back(ref_model(bus.a, bus.b, bus.cin, bus.sub));
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            if (expq.size() == 0) begin
               check("drain_spurious", 32'(bus.out_valid), 32'd0);
            end else begin
               e = expq.pop_front();
               check("drain_result", {14'd0, bus.overflow, bus.carry, bus.sum}, {14'd0, e});
            end
         end
      end
      check("rnd_all_delivered", 32'(expq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
